multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter DataWidth, default 16, operand/result width; even, >= 4.
REQ-002 The block SHALL have parameter CountWidth, default $clog2(DataWidth)+1, iteration counter width.
REQ-003 The block SHALL have port Clock, input, 1, sole clock; all state changes on rising edge.
REQ-004 The block SHALL have port nReset, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port Start, input, 1, request; sampled only in IDLE or DONE.
REQ-006 The block SHALL have port Operation, input, eOperation (InstructionSetPkg), opcode; captured with Start.
REQ-007 The block SHALL have port InFlags, input, sFlags, incoming flags; captured with Start.
REQ-008 The block SHALL have ports InSrc and InDest, input, DataWidth each, signed operands; captured with Start.
REQ-009 The block SHALL have port Busy, output, 1, high from accept edge until the result edge.
REQ-010 The block SHALL have port Done, output, 1, one-cycle pulse marking OutDest/OutFlags valid.
REQ-011 The block SHALL have ports OutDest (output, DataWidth, registered signed result) and OutFlags (output, sFlags, registered flags).

Function
REQ-012 The FSM SHALL have states IDLE, RUN_MUL, RUN_DIV and DONE.
REQ-013 IDLE/DONE with Start=1: capture inputs; single-cycle ops go to DONE; MUL/MUH go to RUN_MUL; DIV/MOD go to RUN_DIV.
REQ-014 DONE with Start=0 SHALL go to IDLE, and Done SHALL be high only while in DONE.
REQ-015 Start while Busy SHALL be ignored, with no effect on state or captured operands.
REQ-016 Single-cycle ops (NAND, NOR, ROL, ROR, MOVE, ADC, SUB) SHALL write the result on the accept edge, giving Done in the next cycle (latency 1).
REQ-017 Single-cycle op behaviour:
  - ROL: {C,R} = {Src,Cin}.
  - ROR: {R,C} = {Cin,Src}.
  - ADC: {C,R} = Dest+Src+Cin.
  - SUB: R = Dest-Src-Cin, C = borrow.
REQ-018 ADC/SUB SHALL update Z, N, V (signed overflow) and P (P = ~^R).
REQ-019 Logic ops and MOVE SHALL leave all flags equal to InFlags.
REQ-020 RUN_MUL SHALL perform signed shift-add of magnitudes, one partial product per cycle for DataWidth cycles, then apply sign fix-up on the final edge.
REQ-021 MUL SHALL return product bits [DataWidth-1:0]; MUH SHALL return bits [2*DataWidth-1:DataWidth] of the full 2*DataWidth signed product.
REQ-022 RUN_DIV SHALL perform restoring division on magnitudes, one quotient bit per cycle for DataWidth cycles, then apply sign fix-up.
REQ-023 DIV SHALL truncate toward zero; the MOD remainder SHALL take the sign of Dest.
REQ-024 Iterative op latency SHALL be DataWidth+2 cycles from the accept edge to Done high.
REQ-025 Iterative ops SHALL update Z, N, P from the final result; C SHALL pass through from InFlags.
REQ-026 Iterative ops SHALL set V=0, except under REQ-027/REQ-028.
REQ-027 Divide by zero (Src=0): DIV SHALL return all-ones and MOD SHALL return Dest, with V=1 and the same latency.
REQ-028 DIV of the most-negative value by -1 SHALL return the most-negative value with V=1; MOD in that case SHALL return 0.
REQ-029 Unlisted opcodes SHALL return OutDest=0 with flags = InFlags, at latency 1.
REQ-030 OutDest/OutFlags SHALL hold their last value outside DONE.

Reset
REQ-031 nReset low SHALL immediately force: state IDLE, Busy=0, Done=0, OutDest=0, OutFlags=all 0, counter=0.
REQ-032 Reset mid-iteration SHALL abandon the operation, and no Done SHALL follow.
REQ-033 The first Start sampled after nReset deasserts SHALL be accepted normally.

Verification (DataWidth=16)
REQ-034 ADC Src=0x0001, Dest=0x7FFF, C=0 -> OutDest 0x8000, N=1, V=1, Z=0, C=0; Done 1 cycle after accept.
REQ-035 MUL then MUH with Src=5, Dest=-3 -> 0xFFF1 then 0xFFFF, each with Done exactly 18 cycles after accept, Busy high 17 cycles.
REQ-036 DIV Dest=-7, Src=2 -> 0xFFFD (-3), N=1; MOD same operands -> 0xFFFF (-1).
REQ-037 DIV Dest=100, Src=0 -> 0xFFFF, V=1; MOD -> 0x0064, V=1; DIV 0x8000 by 0xFFFF -> 0x8000, V=1.
REQ-038 Start DIV, pulse nReset low at cycle 5 -> Busy/Done/OutDest 0 at once, no Done afterwards; then MOVE Src=0x1234 -> 0x1234 at latency 1.
REQ-039 Start held high through Busy -> ignored; Start high in DONE with NOR 0x00FF/0x0F00 -> 0xF000 accepted back-to-back, giving Done on two consecutive operations.

Source files
------------

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu (plus package InstructionSetPkg)
// Description : Small ALU with single-cycle logic/shift/add operations and
//               iterative signed multiply (shift-add) and signed divide
//               (restoring). Operands are captured with Start. The result
//               and flags are presented with a one-cycle Done pulse.
// Ports       : Clock     - sole clock, rising edge
//               nReset    - asynchronous, active-low reset
//               Start     - request, sampled only in IDLE or DONE
//               Operation - opcode (eOperation), captured with Start
//               InFlags   - incoming flags (sFlags), captured with Start
//               InSrc     - signed source operand
//               InDest    - signed destination operand
//               Busy      - high while an iterative operation runs
//               Done      - one-cycle pulse, OutDest/OutFlags valid
//               OutDest   - registered signed result
//               OutFlags  - registered result flags
// Revision    : 1.0 - initial release
// ============================================================================

package InstructionSetPkg;

  typedef enum logic [3:0] {
    OP_NAND = 4'h0,
    OP_NOR  = 4'h1,
    OP_ROL  = 4'h2,
    OP_ROR  = 4'h3,
    OP_MOVE = 4'h4,
    OP_ADC  = 4'h5,
    OP_SUB  = 4'h6,
    OP_MUL  = 4'h7,
    OP_MUH  = 4'h8,
    OP_DIV  = 4'h9,
    OP_MOD  = 4'hA
  } eOperation;

  // First member is the most significant bit of the packed value.
  typedef struct packed {
    logic C;
    logic Z;
    logic N;
    logic V;
    logic P;
  } sFlags;

endpackage

module multicycle_alu
  import InstructionSetPkg::*;
#(
  parameter int DataWidth  = 16,
  parameter int CountWidth = $clog2(DataWidth) + 1
) (
  input  logic                        Clock,
  input  logic                        nReset,
  input  logic                        Start,
  input  eOperation                   Operation,
  input  sFlags                       InFlags,
  input  logic signed [DataWidth-1:0] InSrc,
  input  logic signed [DataWidth-1:0] InDest,
  output logic                        Busy,
  output logic                        Done,
  output logic signed [DataWidth-1:0] OutDest,
  output sFlags                       OutFlags
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN_MUL = 2'd1;
  localparam logic [1:0] RUN_DIV = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // The counter reaches this value after the last partial product / quotient
  // bit; the edge that sees it applies the sign fix-up and writes the result.
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(DataWidth);

  localparam logic [DataWidth-1:0] MostNegative = {1'b1, {(DataWidth-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State and captured operation context
  // --------------------------------------------------------------------------
  logic [1:0]            state;
  logic [CountWidth-1:0] count;
  eOperation             op_q;
  sFlags                 flags_q;
  logic [DataWidth-1:0]  dest_q;
  logic                  neg_prod;   // sign of product / quotient
  logic                  neg_rem;    // sign of remainder (follows Dest)
  logic                  div_zero;
  logic                  div_ovf;    // most-negative divided by -1

  // Shared iteration datapath. Multiply: acc_hi = running upper half,
  // acc_lo = multiplier shifting out / product low half shifting in.
  // Divide: acc_hi = partial remainder, acc_lo = dividend shifting out /
  // quotient shifting in. operand_b is the multiplicand or divisor magnitude.
  logic [DataWidth-1:0]  acc_hi;
  logic [DataWidth-1:0]  acc_lo;
  logic [DataWidth-1:0]  operand_b;

  logic                  accept;

  function automatic logic [DataWidth-1:0] magnitude(input logic [DataWidth-1:0] value);
    // The most-negative value maps to 2**(DataWidth-1), which still fits
    // when read as unsigned.
    return value[DataWidth-1] ? -value : value;
  endfunction

  function automatic sFlags result_flags(input logic [DataWidth-1:0] value,
                                         input sFlags                base,
                                         input logic                 overflow);
    sFlags f;
    f   = base;
    f.Z = (value == '0);
    f.N = value[DataWidth-1];
    f.V = overflow;
    f.P = ~^value;
    return f;
  endfunction

  assign accept = ((state == IDLE) || (state == DONE)) && Start;
  assign Busy   = (state == RUN_MUL) || (state == RUN_DIV);
  assign Done   = (state == DONE);

  // --------------------------------------------------------------------------
  // Single-cycle operations, evaluated on the live inputs at the accept edge
  // --------------------------------------------------------------------------
  logic [DataWidth-1:0] single_res;
  sFlags                single_flags;
  logic [DataWidth:0]   arith_u;   // zero-extended: carry / borrow out
  logic [DataWidth:0]   arith_s;   // sign-extended: signed overflow
  logic [DataWidth:0]   cin_ext;

  always_comb begin
    single_res   = '0;
    single_flags = InFlags;
    cin_ext      = {{DataWidth{1'b0}}, InFlags.C};
    arith_u      = '0;
    arith_s      = '0;
    case (Operation)
      OP_NAND: single_res = ~(InDest & InSrc);
      OP_NOR:  single_res = ~(InDest | InSrc);
      OP_ROL: begin
        single_res     = {InSrc[DataWidth-2:0], InFlags.C};
        single_flags.C = InSrc[DataWidth-1];
      end
      OP_ROR: begin
        single_res     = {InFlags.C, InSrc[DataWidth-1:1]};
        single_flags.C = InSrc[0];
      end
      OP_MOVE: single_res = InSrc;
      OP_ADC: begin
        arith_u      = {1'b0, InDest} + {1'b0, InSrc} + cin_ext;
        arith_s      = {InDest[DataWidth-1], InDest} + {InSrc[DataWidth-1], InSrc} + cin_ext;
        single_res   = arith_u[DataWidth-1:0];
        single_flags = result_flags(arith_u[DataWidth-1:0], InFlags,
                                    arith_s[DataWidth] ^ arith_s[DataWidth-1]);
        single_flags.C = arith_u[DataWidth];
      end
      OP_SUB: begin
        arith_u      = {1'b0, InDest} - {1'b0, InSrc} - cin_ext;
        arith_s      = {InDest[DataWidth-1], InDest} - {InSrc[DataWidth-1], InSrc} - cin_ext;
        single_res   = arith_u[DataWidth-1:0];
        single_flags = result_flags(arith_u[DataWidth-1:0], InFlags,
                                    arith_s[DataWidth] ^ arith_s[DataWidth-1]);
        // Bit DataWidth of the zero-extended difference is the borrow.
        single_flags.C = arith_u[DataWidth];
      end
      default: begin
        // Unlisted opcodes yield zero and pass the flags through.
        single_res   = '0;
        single_flags = InFlags;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One iteration step of each iterative algorithm
  // --------------------------------------------------------------------------
  logic [DataWidth:0] mul_sum;
  logic [DataWidth:0] div_shift;
  logic [DataWidth:0] div_diff;
  logic               div_ok;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
    div_shift = {acc_hi, acc_lo[DataWidth-1]};
    div_diff  = div_shift - {1'b0, operand_b};
    div_ok    = ~div_diff[DataWidth];
  end

  // --------------------------------------------------------------------------
  // Sign fix-up and special cases applied on the final iterative edge
  // --------------------------------------------------------------------------
  logic [2*DataWidth-1:0] mul_full;
  logic [2*DataWidth-1:0] mul_signed;
  logic [DataWidth-1:0]   quot_signed;
  logic [DataWidth-1:0]   rem_signed;
  logic [DataWidth-1:0]   final_res;
  logic                   final_v;
  sFlags                  final_flags;

  always_comb begin
    mul_full    = {acc_hi, acc_lo};
    mul_signed  = neg_prod ? -mul_full : mul_full;
    quot_signed = neg_prod ? -acc_lo : acc_lo;
    rem_signed  = neg_rem ? -acc_hi : acc_hi;
    final_res   = '0;
    final_v     = 1'b0;
    if (state == RUN_MUL) begin
      final_res = (op_q == OP_MUH) ? mul_signed[2*DataWidth-1:DataWidth]
                                   : mul_signed[DataWidth-1:0];
    end else if (div_zero) begin
      final_res = (op_q == OP_MOD) ? dest_q : '1;
      final_v   = 1'b1;
    end else begin
      // The most-negative / -1 case already produces the most-negative
      // quotient and a zero remainder; only V needs forcing.
      final_res = (op_q == OP_MOD) ? rem_signed : quot_signed;
      final_v   = div_ovf;
    end
    final_flags = result_flags(final_res, flags_q, final_v);
  end

  // --------------------------------------------------------------------------
  // Control and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      count     <= '0;
      op_q      <= OP_NAND;
      flags_q   <= '0;
      dest_q    <= '0;
      neg_prod  <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      div_ovf   <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      OutDest   <= '0;
      OutFlags  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q     <= Operation;
            flags_q  <= InFlags;
            dest_q   <= InDest;
            count    <= '0;
            neg_prod <= InDest[DataWidth-1] ^ InSrc[DataWidth-1];
            neg_rem  <= InDest[DataWidth-1];
            div_zero <= (InSrc == '0);
            div_ovf  <= (InDest == MostNegative) && (&InSrc);
            acc_hi   <= '0;
            case (Operation)
              OP_MUL, OP_MUH: begin
                state     <= RUN_MUL;
                acc_lo    <= magnitude(InSrc);
                operand_b <= magnitude(InDest);
              end
              OP_DIV, OP_MOD: begin
                state     <= RUN_DIV;
                acc_lo    <= magnitude(InDest);
                operand_b <= magnitude(InSrc);
              end
              default: begin
                state    <= DONE;
                OutDest  <= single_res;
                OutFlags <= single_flags;
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end

        RUN_MUL: begin
          if (count == LastCount) begin
            state    <= DONE;
            OutDest  <= final_res;
            OutFlags <= final_flags;
          end else begin
            acc_hi <= mul_sum[DataWidth:1];
            acc_lo <= {mul_sum[0], acc_lo[DataWidth-1:1]};
            count  <= count + CountWidth'(1);
          end
        end

        RUN_DIV: begin
          if (count == LastCount) begin
            state    <= DONE;
            OutDest  <= final_res;
            OutFlags <= final_flags;
          end else begin
            // Restore by simply keeping the shifted remainder when the
            // trial subtraction goes negative.
            acc_hi <= div_ok ? div_diff[DataWidth-1:0] : div_shift[DataWidth-1:0];
            acc_lo <= {acc_lo[DataWidth-2:0], div_ok};
            count  <= count + CountWidth'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
